// File: rtl/change_capture_pkg.sv
// change_capture_pkg: shared types and constants for the change_capture block.
//   cap_state_e : capture FSM states (idle / armed)
//   DropCntW    : width of the saturating dropped-change counter
//   cap_rec_t   : {timestamp, value} record at the default DATA_W/TS_W widths
//   sat_inc     : saturating increment for the drop counter
package change_capture_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StArmed
  } cap_state_e;

  localparam int unsigned DropCntW = 16;
  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefTsW   = 32;

  typedef struct packed {
    logic [DefTsW-1:0]   ts;
    logic [DefDataW-1:0] data;
  } cap_rec_t;

  function automatic logic [DropCntW-1:0] sat_inc(input logic [DropCntW-1:0] v);
    return (v == {DropCntW{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/change_capture_if.sv
// change_capture_if: ready/valid record stream from the capture stage to its consumer.
//   o_valid : head record available        (master -> slave)
//   o_data  : head record value            (master -> slave)
//   o_ts    : head record timestamp        (master -> slave)
//   i_ready : consumer accepts head record (slave -> master)
interface change_capture_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TS_W   = 32
);
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [TS_W-1:0]   o_ts;

  modport master (output o_valid, output o_data, output o_ts, input i_ready);
  modport slave  (input o_valid, input o_data, input o_ts, output i_ready);
endinterface

// File: rtl/change_capture_fifo.sv
// capture_fifo: first-word-fall-through FIFO holding captured records.
//   clock, reset : clock and asynchronous active-low reset
//   push, wdata  : write one entry (caller never pushes while full without a pop)
//   pop          : remove head entry (caller never pops while empty)
//   rdata        : head entry, valid whenever !empty
//   full, empty  : occupancy flags; count : current occupancy (0..DEPTH)
module capture_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage is deliberately not reset; the parent masks outputs while empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_q[AW-1:0]] <= wdata;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = wr_q - rd_q;
  assign rdata = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/change_capture.sv
// change_capture: records every cycle in which i_value changes into a FIFO drained
// over a ready/valid stream. Optional macro CHANGE_CAPTURE_TIMESTAMP_EN adds a
// free-running timestamp to each record; without it out.o_ts is tied to 0.
//   clock, reset : clock and asynchronous active-low reset
//   i_enable     : capture enable; each enable from idle emits a baseline record
//   i_value      : monitored value, sampled every rising edge
//   out          : record stream (o_valid/o_data/o_ts/i_ready)
//   o_count      : FIFO occupancy
//   o_drop_cnt   : saturating count of changes lost to a full FIFO
//   o_overflow   : sticky, set on the first dropped change
module change_capture
  import change_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TS_W   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [DATA_W-1:0]      i_value,
  change_capture_if.master       out,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DropCntW-1:0]    o_drop_cnt,
  output logic                   o_overflow
);

`ifdef CHANGE_CAPTURE_TIMESTAMP_EN
  localparam int unsigned EntryW = DATA_W + TS_W;
`else
  localparam int unsigned EntryW = DATA_W;
`endif

  cap_state_e          state_q, state_d;
  logic [DATA_W-1:0]   prev_q;
  logic [DropCntW-1:0] drop_q;
  logic                ovf_q;
  logic                push_req, push, pop, drop;
  logic                full, empty;
  logic [EntryW-1:0]   wdata, rdata;

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_enable) begin
          push_req = 1'b1;
          state_d  = StArmed;
        end
      end
      StArmed: begin
        if (!i_enable)             state_d  = StIdle;
        else if (i_value != prev_q) push_req = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pop  = !empty && out.i_ready;
  assign drop = push_req && full && !pop;
  assign push = push_req && !drop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      prev_q  <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Dropped changes still advance prev so they are never re-reported.
      if (push_req) prev_q <= i_value;
      if (drop) begin
        drop_q <= sat_inc(drop_q);
        ovf_q  <= 1'b1;
      end
    end
  end

`ifdef CHANGE_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  assign wdata    = {ts_q, i_value};
  assign out.o_ts = empty ? '0 : rdata[EntryW-1:DATA_W];
`else
  assign wdata    = i_value;
  assign out.o_ts = {TS_W{1'b0}};
`endif

  capture_fifo #(
    .WIDTH(EntryW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(wdata),
    .rdata(rdata),
    .full (full),
    .empty(empty),
    .count(o_count)
  );

  assign out.o_valid = !empty;
  assign out.o_data  = empty ? '0 : rdata[DATA_W-1:0];
  assign o_drop_cnt  = drop_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_change_capture.sv
module tb_change_capture;
  import change_capture_pkg::*;

  localparam int unsigned DataW = 64;
  localparam int unsigned TsW   = 32;
  localparam int unsigned Depth = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             i_enable = 1'b0;
  logic [DataW-1:0] i_value = '0;
  logic [3:0]       o_count;
  logic [15:0]      o_drop_cnt;
  logic             o_overflow;

  change_capture_if #(.DATA_W(DataW), .TS_W(TsW)) cif ();

  change_capture #(
    .DATA_W(DataW),
    .DEPTH (Depth),
    .TS_W  (TsW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_enable  (i_enable),
    .i_value   (i_value),
    .out       (cif.master),
    .o_count   (o_count),
    .o_drop_cnt(o_drop_cnt),
    .o_overflow(o_overflow)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a bounded record buffer with drop accounting.
  cap_rec_t    exp_q[$];
  int          m_occ   = 0;
  int          m_drops = 0;
  bit          m_ovf   = 0;
  bit          m_armed = 0;
  logic [63:0] m_prev  = '0;
  logic [31:0] m_ts    = '0;
  bit          m_pop, m_chg;

  function automatic logic [31:0] ts_of(input logic [31:0] t);
`ifdef CHANGE_CAPTURE_TIMESTAMP_EN
    return t;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_occ = 0; m_drops = 0; m_ovf = 0; m_armed = 0; m_prev = '0; m_ts = '0;
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      model_clear();
    end else begin
      m_pop = (m_occ > 0) && cif.i_ready;
      m_chg = i_enable && (!m_armed || i_value != m_prev);
      if (m_chg) begin
        m_prev = i_value;
        if (m_occ == Depth && !m_pop) begin
          if (m_drops < 65535) m_drops++;
          m_ovf = 1;
        end else begin
          exp_q.push_back('{ts: ts_of(m_ts), data: i_value});
          m_occ++;
        end
      end
      if (m_pop) m_occ--;
      m_armed = i_enable;
      m_ts++;
    end
  end

  // Monitor: compares the head record whenever one is presented, pops on handshake.
  always @(negedge clock) begin
    if (reset) begin
      chk("valid", 64'(cif.o_valid), 64'(m_occ != 0));
      chk("count", 64'(o_count), 64'(m_occ));
      chk("drop_cnt", 64'(o_drop_cnt), 64'(m_drops));
      chk("overflow", 64'(o_overflow), 64'(m_ovf));
      if (cif.o_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_record: got data 0x%0h, expected no record", cif.o_data);
        end else begin
          chk("data", cif.o_data, exp_q[0].data);
          chk("ts", 64'(cif.o_ts), 64'(exp_q[0].ts));
          if (cif.i_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("data_masked", cif.o_data, 64'd0);
        chk("ts_masked", 64'(cif.o_ts), 64'd0);
      end
    end
  end

  task automatic step(input bit en, input logic [63:0] v, input bit rdy);
    @(posedge clock);
    #1;
    i_enable  = en;
    i_value   = v;
    cif.i_ready = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, i_value, 1'b1);
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, "_valid"}, 64'(cif.o_valid), 64'd0);
    chk({tag, "_count"}, 64'(o_count), 64'd0);
    chk({tag, "_drop"}, 64'(o_drop_cnt), 64'd0);
    chk({tag, "_ovf"}, 64'(o_overflow), 64'd0);
  endtask

  initial begin
    cif.i_ready = 1'b0;
    #3;
    check_zero_state("reset");
    chk("reset_data", cif.o_data, 64'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    // Held value: one baseline record only.
    for (int i = 0; i < 10; i++) step(1'b1, 64'd5, 1'b1);
    idle(3);

    // Counter pattern with consecutive timestamps.
    for (int i = 0; i < 4; i++) step(1'b1, 64'(i), 1'b1);
    idle(3);

    // Overflow: ten distinct values into a stalled FIFO.
    for (int i = 0; i < 10; i++) step(1'b1, 64'(100 + i), 1'b0);
    step(1'b1, 64'd109, 1'b0);
    @(negedge clock);
    chk("ovf_count", 64'(o_count), 64'd8);
    chk("ovf_drops", 64'(o_drop_cnt), 64'd2);
    chk("ovf_sticky", 64'(o_overflow), 64'd1);

    // Full FIFO: pop and push in the same cycle.
    step(1'b1, 64'd200, 1'b1);
    step(1'b1, 64'd200, 1'b0);
    @(negedge clock);
    chk("full_pp_count", 64'(o_count), 64'd8);
    chk("full_pp_drops", 64'(o_drop_cnt), 64'd2);
    idle(12);

    // Enable toggle with an unchanged value: two baselines.
    for (int i = 0; i < 3; i++) step(1'b1, 64'hAA, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 64'hAA, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 64'hAA, 1'b1);
    idle(3);

    // Mid-operation reset with three records buffered.
    for (int i = 0; i < 10; i++) step(1'b1, 64'(300 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 64'd309, 1'b1);
    step(1'b0, 64'd309, 1'b0);
    @(negedge clock);
    chk("pre_reset_count", 64'(o_count), 64'd3);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_zero_state("mid_reset");
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b1, 64'h77, 1'b0);
    step(1'b1, 64'h77, 1'b0);
    @(negedge clock);
    chk("post_reset_baseline", cif.o_data, 64'h77);
    chk("post_reset_ts_small", 64'(cif.o_ts < 32'd4), 64'd1);
    idle(3);

    // Randomized traffic with frequent repeats and backpressure.
    for (int i = 0; i < 2000; i++)
      step(($urandom % 8) != 0, 64'($urandom % 4), ($urandom % 2) != 0);
    idle(Depth + 4);
    @(negedge clock);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/change_capture.md
# change_capture

Value-change capture stage that sits directly downstream of the design under test. It watches one wide signal, such as the `top` free-running `counter` or `value64`. Every cycle in which that signal differs from its previous sample, it pushes a timestamped record into an internal FIFO. A ready/valid consumer (the DPI/Lua-side monitor shim) drains the records in order, so value changes are never lost between simulator callbacks unless the buffer overflows, and overflow is counted.

## Interface
Parameters:
- `DATA_W`, 64: width of the monitored value.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `TS_W`, 32: timestamp counter width.

Ports:
- `clock`  input  1  single clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `i_enable`  input  1  capture enable.
- `i_value`  input  DATA_W  monitored value, sampled every rising edge.
- `o_valid`  output  1  head record available.
- `i_ready`  input  1  consumer accepts head record.
- `o_data`  output  DATA_W  head record value.
- `o_ts`  output  TS_W  head record timestamp (see Configuration).
- `o_count`  output  $clog2(DEPTH)+1  current occupancy.
- `o_drop_cnt`  output  16  dropped changes, saturating at 16'hFFFF.
- `o_overflow`  output  1  sticky; set on first drop.

## Operation
- Capture FSM has two states, IDLE and ARMED; reset → IDLE.
- IDLE:
  - `i_enable`=1 pushes a baseline record of `i_value`, loads `prev`, and moves to ARMED.
  - `i_enable`=0 stays in IDLE.
- ARMED:
  - `i_enable`=1 and `i_value`≠`prev` pushes a record and updates `prev`.
  - `i_enable`=1 and `i_value`=`prev` pushes nothing.
  - `i_enable`=0 moves to IDLE with no push; `prev` frozen.
- `prev` updates on every detected change, including dropped ones. A drop therefore never causes a duplicate record later.
- Timestamp counter:
  - Free-running from reset and independent of `i_enable`.
  - Increments by 1 every cycle and wraps from 2^TS_W−1 to 0.
  - A record carries the counter value of the edge at which the change was sampled.
- FIFO:
  - First-word-fall-through.
  - `o_valid` = occupancy ≠ 0.
  - Pop occurs when `o_valid` && `i_ready`.
- Full and push with no pop: the record is dropped, `o_drop_cnt` increments (saturating), and `o_overflow` is set.
- Full and push with pop in the same cycle: both succeed and occupancy stays at DEPTH.
- Empty with `i_ready`=1: no effect.
- `o_data`/`o_ts` are held stable while `o_valid` && !`i_ready`.
- Pointers are log2(DEPTH)+1 bits wide; full/empty is decided by the MSB compare.
- Reset values:
  - FSM IDLE.
  - `prev`, timestamp counter, pointers, `o_count`, `o_drop_cnt` = 0.
  - `o_overflow` = 0, `o_valid` = 0.
  - `o_data` and `o_ts` = 0; storage is not reset, but the outputs are masked to 0 while empty.

## Timing
- Change sampled at edge N → record visible (`o_valid`=1) after edge N if the FIFO was empty: one-cycle latency.
- Pop at edge N → next record on outputs after edge N; back-to-back pops sustain 1 record per cycle.
- Reset asserted mid-operation clears all state immediately, discarding buffered records. The first capture after deassertion requires `i_enable`, and the first record is a baseline.
- The `o_count` update is visible the cycle after the push/pop edge.

## Configuration
- `CHANGE_CAPTURE_TIMESTAMP_EN` defined:
  - Timestamp counter present.
  - FIFO entry width is DATA_W+TS_W.
  - `o_ts` carries the capture timestamp.
- Not defined:
  - No timestamp counter.
  - Entry width is DATA_W.
  - `o_ts` is tied to 0; the port list is unchanged.

## Structure
- Package `change_capture_pkg`: FSM state enum (IDLE, ARMED), drop-counter width constant (16), and a record struct type built from DATA_W/TS_W.
- One sub-module, `capture_fifo`:
  - Parameterised FWFT FIFO with `full`/`empty`/`count`.
  - The drop decision stays in the parent.

## Test plan
- Enable with `i_value`=5 held for 10 cycles, `i_ready`=1 → exactly one baseline record with data 5, then `o_valid` stays 0.
- Drive the `counter` pattern 0,1,2,3 on consecutive cycles with `i_ready`=1 → 4 records with consecutive timestamps T..T+3; each appears one cycle after its sample.
- DEPTH=8, `i_ready`=0, 10 distinct values → `o_count`=8, `o_drop_cnt`=2, `o_overflow`=1. Draining yields the first 8 values in order.
- Full FIFO with `i_ready`=1 and a new change in the same cycle → `o_count` stays 8, `o_drop_cnt` unchanged, and the new value is delivered last.
- Toggle `i_enable` 1→0→1 with `i_value` unchanged at 0xAA → two baseline records of 0xAA; no records are produced while disabled.
- Assert reset with 3 records buffered → `o_valid`, `o_count`, `o_drop_cnt`, and `o_overflow` are 0 during the same cycle. With TIMESTAMP_EN, the first post-reset timestamp is small.
